// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side and memory-side signals of the line-to-burst adapter.
interface cacheline_burst_adapter_if #(
  parameter int unsigned LINE_W  = 256,
  parameter int unsigned BURST_W = 64
);
  // Cache side
  logic [LINE_W-1:0]  line_i;
  logic [LINE_W-1:0]  line_o;
  logic [31:0]        address_i;
  logic               read_i;
  logic               write_i;
  logic               resp_o;
  // Memory side
  logic [BURST_W-1:0] burst_i;
  logic [BURST_W-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i;

  // Adapter view
  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  // Cache controller / memory model view
  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one cache-line read/write-back request into a burst of memory beats.
module cacheline_burst_adapter #(
  parameter int unsigned LINE_W   = 256,
  parameter int unsigned BURST_W  = 64,
  parameter int unsigned BEATS    = 4,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  cacheline_burst_adapter_if.slave  bus
);

  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   wline_q, wline_d;
  logic [LINE_W-1:0]   rline_q, rline_d;
  logic [BURST_W-1:0]  burst_q, burst_d;
  logic                read_q, read_d;
  logic                write_q, write_d;
  logic                resp_q, resp_d;

  logic                last_beat;
  logic [CNT_W-1:0]    cnt_inc;

  assign last_beat = (cnt_q == CNT_W'(BEATS - 1));
  assign cnt_inc   = cnt_q + CNT_W'(1);

  // Next-state and registered-output computation
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    burst_d = burst_q;
    read_d  = read_q;
    write_d = write_q;
    resp_d  = 1'b0;

    case (state_q)
      IDLE: begin
        // Write wins when both requests are raised; the read is re-sampled later
        if (bus.write_i) begin
          wline_d = bus.line_i;
          addr_d  = {bus.address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          burst_d = bus.line_i[BURST_W-1:0];
          write_d = 1'b1;
          state_d = WR;
        end else if (bus.read_i) begin
          addr_d  = {bus.address_i[31:OFFSET_W], {OFFSET_W{1'b0}}};
          cnt_d   = '0;
          read_d  = 1'b1;
          state_d = RD;
        end
      end

      RD: begin
        if (bus.resp_i) begin
          rline_d[BURST_W*cnt_q +: BURST_W] = bus.burst_i;
          if (last_beat) begin
            cnt_d   = '0;
            read_d  = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end

      WR: begin
        if (bus.resp_i) begin
          if (last_beat) begin
            cnt_d   = '0;
            write_d = 1'b0;
            resp_d  = 1'b1;
            state_d = DONE;
          end else begin
            // Present the following beat from the latched line
            cnt_d   = cnt_inc;
            burst_d = wline_q[BURST_W*cnt_inc +: BURST_W];
          end
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any burst in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
      burst_q <= '0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
      resp_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
      burst_q <= burst_d;
      read_q  <= read_d;
      write_q <= write_d;
      resp_q  <= resp_d;
    end
  end

  assign bus.line_o    = rline_q;
  assign bus.burst_o   = burst_q;
  assign bus.address_o = addr_q;
  assign bus.read_o    = read_q;
  assign bus.write_o   = write_q;
  assign bus.resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Randomized self-checking bench for cacheline_burst_adapter.
module tb_cacheline_burst_adapter;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  logic [255:0] last_line;

  cacheline_burst_adapter_if bus ();

  cacheline_burst_adapter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Cache controller + memory model for one line fill; expected line is the beats handed out
  task automatic do_read(input logic [31:0] addr, input logic [255:0] beats,
                         input bit use_pat, input logic [31:0] pat,
                         input int gap_pct, input int abort_after);
    int k;
    int cyc;
    bit r;
    @(negedge clk);
    bus.read_i    = 1'b1;
    bus.address_i = addr;
    cyc = 0;
    while (bus.read_o !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (bus.read_o !== 1'b1) begin
      bad++; $display("FAIL rd_start read_o=%b required 1", bus.read_o);
    end
    total++;
    if (bus.write_o !== 1'b0) begin
      bad++; $display("FAIL rd_no_write write_o=%b required 0", bus.write_o);
    end
    total++;
    if (bus.address_o !== (addr & 32'hFFFF_FFE0)) begin
      bad++; $display("FAIL rd_addr address_o=%h required %h", bus.address_o, addr & 32'hFFFF_FFE0);
    end
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 300) begin
      total++;
      if (bus.read_o !== 1'b1 || bus.resp_o !== 1'b0) begin
        bad++; $display("FAIL rd_busy read_o=%b resp_o=%b required 1/0", bus.read_o, bus.resp_o);
      end
      if (use_pat && cyc < 32) r = pat[cyc];
      else r = ($urandom_range(99) >= gap_pct);
      if (r) begin
        bus.resp_i  = 1'b1;
        bus.burst_i = beats[64*k +: 64];
        k++;
      end else begin
        bus.resp_i  = 1'b0;
        bus.burst_i = {$urandom, $urandom};
      end
      if (bus.line_i !== 'x) bus.line_i = rand256();
      @(negedge clk);
      cyc++;
      if (abort_after != 0 && k == abort_after) break;
    end
    if (abort_after != 0) begin
      reset_n = 1'b0;
      #1;
      total++;
      if (bus.line_o !== '0 || bus.burst_o !== '0 || bus.address_o !== '0 ||
          bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
        bad++;
        $display("FAIL abort_outputs read_o=%b write_o=%b resp_o=%b addr=%h line_o=%h required all 0",
                 bus.read_o, bus.write_o, bus.resp_o, bus.address_o, bus.line_o);
      end
      bus.read_i = 1'b0;
      bus.resp_i = 1'b0;
      last_line  = '0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        total++;
        if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin
          bad++; $display("FAIL abort_quiet resp_o=%b read_o=%b required 0/0", bus.resp_o, bus.read_o);
        end
      end
    end else begin
      total++;
      if (k != 4) begin
        bad++; $display("FAIL rd_timeout beats=%0d required 4", k);
      end
      total++;
      if (bus.resp_o !== 1'b1 || bus.read_o !== 1'b0) begin
        bad++; $display("FAIL rd_done resp_o=%b read_o=%b required 1/0", bus.resp_o, bus.read_o);
      end
      total++;
      if (bus.line_o !== beats) begin
        bad++; $display("FAIL rd_line line_o=%h required %h", bus.line_o, beats);
      end
      // Controller drops the request in DONE; memory strays a strobe
      bus.read_i  = 1'b0;
      bus.resp_i  = 1'($urandom_range(1));
      bus.burst_i = {$urandom, $urandom};
      last_line   = beats;
      @(negedge clk);
      bus.resp_i = 1'b0;
      total++;
      if (bus.resp_o !== 1'b0 || bus.read_o !== 1'b0) begin
        bad++; $display("FAIL rd_one_pulse resp_o=%b read_o=%b required 0/0", bus.resp_o, bus.read_o);
      end
      total++;
      if (bus.line_o !== beats) begin
        bad++; $display("FAIL rd_line_hold line_o=%h required %h", bus.line_o, beats);
      end
    end
  endtask

  // Write-back: memory consumes burst_o on each strobe; must see the line as originally presented
  task automatic do_write(input logic [31:0] addr, input logic [255:0] line,
                          input int gap_pct, input bit scramble, input bit with_read);
    int k;
    int cyc;
    @(negedge clk);
    bus.write_i   = 1'b1;
    bus.read_i    = with_read;
    bus.line_i    = line;
    bus.address_i = addr;
    cyc = 0;
    while (bus.write_o !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (bus.write_o !== 1'b1 || bus.read_o !== 1'b0) begin
      bad++; $display("FAIL wr_start write_o=%b read_o=%b required 1/0", bus.write_o, bus.read_o);
    end
    total++;
    if (bus.address_o !== (addr & 32'hFFFF_FFE0)) begin
      bad++; $display("FAIL wr_addr address_o=%h required %h", bus.address_o, addr & 32'hFFFF_FFE0);
    end
    k = 0;
    cyc = 0;
    while (k < 4 && cyc < 300) begin
      total++;
      if (bus.write_o !== 1'b1 || bus.resp_o !== 1'b0) begin
        bad++; $display("FAIL wr_busy write_o=%b resp_o=%b required 1/0", bus.write_o, bus.resp_o);
      end
      if (scramble) begin
        bus.line_i    = rand256();
        bus.address_i = $urandom;
      end
      if ($urandom_range(99) >= gap_pct) begin
        total++;
        if (bus.burst_o !== line[64*k +: 64]) begin
          bad++; $display("FAIL wr_beat%0d burst_o=%h required %h", k, bus.burst_o, line[64*k +: 64]);
        end
        bus.resp_i = 1'b1;
        k++;
      end else begin
        bus.resp_i = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    total++;
    if (k != 4) begin
      bad++; $display("FAIL wr_timeout beats=%0d required 4", k);
    end
    total++;
    if (bus.resp_o !== 1'b1 || bus.write_o !== 1'b0) begin
      bad++; $display("FAIL wr_done resp_o=%b write_o=%b required 1/0", bus.resp_o, bus.write_o);
    end
    total++;
    if (bus.line_o !== last_line) begin
      bad++; $display("FAIL wr_line_o line_o=%h required %h", bus.line_o, last_line);
    end
    bus.write_i   = 1'b0;
    bus.address_i = addr;
    bus.resp_i    = 1'($urandom_range(1));
    @(negedge clk);
    bus.resp_i = 1'b0;
    total++;
    if (bus.resp_o !== 1'b0 || bus.write_o !== 1'b0) begin
      bad++; $display("FAIL wr_one_pulse resp_o=%b write_o=%b required 0/0", bus.resp_o, bus.write_o);
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    last_line     = '0;
    repeat (3) @(negedge clk);
    total++;
    if (bus.line_o !== '0 || bus.burst_o !== '0 || bus.address_o !== '0 ||
        bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
      bad++; $display("FAIL reset_outputs read_o=%b write_o=%b resp_o=%b required all 0",
                      bus.read_o, bus.write_o, bus.resp_o);
    end
    reset_n = 1'b1;
    @(negedge clk);
    total++;
    if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0) begin
      bad++; $display("FAIL reset_idle read_o=%b write_o=%b resp_o=%b required 0", bus.read_o, bus.write_o, bus.resp_o);
    end
  endtask

  task automatic test_read_fill();
    logic [255:0] b;
    b = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
    do_read(32'h0000_1234, b, 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_write_back();
    logic [255:0] l;
    l = {4{64'h0123_4567_89AB_CDEF}} ^ {64'h0, 64'h1111_0000_0000_0000, 64'h2222, 64'h0};
    do_write(32'h0000_ABCD, l, 0, 1'b0, 1'b0);
  endtask

  task automatic test_gapped_read();
    do_read(32'h8000_003F, rand256(), 1'b1, 32'b1011001, 0, 0);
  endtask

  task automatic test_simultaneous();
    logic [255:0] r;
    r = rand256();
    do_write(32'h0000_4440, rand256(), 30, 1'b0, 1'b1);
    do_read(32'h0000_4440, r, 1'b0, 32'h0, 30, 0);
  endtask

  task automatic test_reset_mid_burst();
    do_read(32'h0000_2000, rand256(), 1'b0, 32'h0, 0, 2);
    do_read(32'h0000_2000, rand256(), 1'b0, 32'h0, 0, 0);
  endtask

  task automatic test_stray_and_scramble();
    repeat (6) begin
      @(negedge clk);
      bus.resp_i  = 1'b1;
      bus.burst_i = {$urandom, $urandom};
      @(negedge clk);
      total++;
      if (bus.read_o !== 1'b0 || bus.write_o !== 1'b0 || bus.resp_o !== 1'b0 || bus.line_o !== last_line) begin
        bad++; $display("FAIL idle_stray read_o=%b write_o=%b resp_o=%b line_o=%h required 0/0/0/%h",
                        bus.read_o, bus.write_o, bus.resp_o, bus.line_o, last_line);
      end
    end
    bus.resp_i = 1'b0;
    do_write($urandom, rand256(), 40, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(1) == 1) do_write($urandom, rand256(), 50, 1'b1, 1'b0);
      else do_read($urandom, rand256(), 1'b0, 32'h0, 50, 0);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_read_fill();
    test_write_back();
    test_gapped_read();
    test_simultaneous();
    test_reset_mid_burst();
    test_stray_and_scramble();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard stop in case a wait is somehow never satisfied
  initial begin
    #2000000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
